loop_nest: RTL

Parametrised N-level nested loop index generator, the multi-dimensional successor to the single-level loop counter. It walks an N-deep loop nest, one iteration per enabled cycle. Each level has its own start and end index, with carry from inner to outer levels. It reports per-level wrap events and whole-nest completion. It sits in the MNIST accelerator control path and drives address generation for conv/fc tiles with the same start/en/next/last handshake style as the existing loop counter.

---
 rtl/loop_pkg.sv | 17 +
 rtl/loop_level.sv | 49 ++++
 rtl/loop_nest.sv | 77 +++++++
 3 files changed

// File: rtl/loop_pkg.sv
// Shared definitions for the nested loop index generator: default sizes,
// the run-state encoding and the per-level bit-slice helper.
package loop_pkg;

    localparam int W_DEF = 16;
    localparam int N_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    function automatic int slice_lo(input int lvl, input int w);
        return lvl * w;
    endfunction

endpackage

// File: rtl/loop_level.sv
// One level of the loop nest: a wrapping counter between ini and fin (inclusive,
// modulo 2^W) that presents ini directly while the nest is not running.
module loop_level #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         live,
    input  logic [W-1:0] ini,
    input  logic [W-1:0] fin,
    input  logic         inc,
    input  logic         load,
    output logic [W-1:0] idx,
    output logic         at_fin
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Presented index and end-of-range flag
    always_comb begin
        if (live) begin
            idx = cnt_q;
        end else begin
            idx = ini;
        end
        at_fin = (idx == fin);
    end

    // Next count; holding the presented value captures ini on a stalled start cycle
    always_comb begin
        if (load) begin
            cnt_d = ini;
        end else if (inc) begin
            if (at_fin) begin
                cnt_d = ini;
            end else begin
                cnt_d = idx + {{(W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = idx;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/loop_nest.sv
// N-level nested loop index generator; level 0 is innermost and carries into
// level 1 when it wraps. Reports per-level wrap and whole-nest done.
module loop_nest
    import loop_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N*W-1:0] ini,
    input  logic [N*W-1:0] fin,
    input  logic         start,
    input  logic         en,
    input  logic         abort,
    output logic [N*W-1:0] idx,
    output logic         valid,
    output logic         busy,
    output logic [N-1:0] wrap,
    output logic         done
);

    run_state_e   state_q;
    logic         live;
    logic         adv;
    logic         load;
    logic [N-1:0] at_fin;
    logic [N-1:0] inc;

    assign live  = (state_q == RUN);
    assign valid = (start | live) & ~rst & ~abort;
    assign adv   = valid & en;
    assign done  = wrap[N-1];
    assign busy  = live;
    // Counters reload whenever the next cycle is idle
    assign load  = ~valid | done;

    // Equality carry chain: level i wraps only when every inner level is at fin
    always_comb begin
        logic chain;
        chain = adv;
        inc   = '0;
        wrap  = '0;
        for (int i = 0; i < N; i++) begin
            inc[i]  = chain;
            chain   = chain & at_fin[i];
            wrap[i] = chain;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_level
        loop_level #(.W(W)) u_level (
            .clk    (clk),
            .live   (live),
            .ini    (ini[slice_lo(g, W) +: W]),
            .fin    (fin[slice_lo(g, W) +: W]),
            .inc    (inc[g]),
            .load   (load),
            .idx    (idx[slice_lo(g, W) +: W]),
            .at_fin (at_fin[g])
        );
    end

    // Run flag: abort and reset cancel, done ends the nest, a live iteration keeps it running
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (abort || done) begin
            state_q <= IDLE;
        end else if (valid) begin
            state_q <= RUN;
        end else begin
            state_q <= state_q;
        end
    end

endmodule
